// File: rtl/uvmt_cv32e40s_rchk_fault_pkg.sv
// Shared types and constants for the rchk fault-injection controller.
// Holds the mode/state encodings and the LFSR step helper.
package uvmt_cv32e40s_rchk_fault_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_RANDOM   = 2'd3
  } rchk_fault_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } rchk_fault_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 as bit positions 15, 13, 12, 10 of a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_rchk_fault_ctrl_if.sv
// OBI handshake and rchk path between the integrity shim and the core.
// master = shim/core side, slave = fault controller.
interface uvmt_cv32e40s_rchk_fault_ctrl_if;

  logic       req;
  logic       gnt;
  logic       integrity;
  logic       rvalid;
  logic [4:0] rchk;
  logic [4:0] rchk_fault;

  modport master (
    output req,
    output gnt,
    output integrity,
    output rvalid,
    output rchk,
    input  rchk_fault
  );

  modport slave (
    input  req,
    input  gnt,
    input  integrity,
    input  rvalid,
    input  rchk,
    output rchk_fault
  );

endinterface

// File: rtl/uvmt_cv32e40s_rchk_fault_fifo.sv
// 1-bit-wide synchronous FIFO holding the integrity attribute of outstanding transactions.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module uvmt_cv32e40s_rchk_fault_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uvmt_cv32e40s_rchk_fault_ctrl.sv
// Schedules rchk corruption on integrity-region OBI responses heading into the core.
// The response path is combinational; scheduling state is updated on the clock edge.
module uvmt_cv32e40s_rchk_fault_ctrl
  import uvmt_cv32e40s_rchk_fault_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_arm_i,
  input  logic [1:0]                           cfg_mode_i,
  input  logic [15:0]                          cfg_interval_i,
  input  logic [4:0]                           cfg_mask_i,
  uvmt_cv32e40s_rchk_fault_ctrl_if.slave       bus,
  output logic                                 inj_now_o,
  output logic [15:0]                          inj_count_o,
  output logic                                 busy_o,
  output logic                                 overflow_err_o,
  output logic                                 underflow_err_o
);

  rchk_fault_state_e state_q;
  rchk_fault_mode_e  mode_q;
  logic [15:0]       interval_q;
  logic [4:0]        mask_q;
  logic [15:0]       cnt_q;
  logic [15:0]       lfsr_q;
  logic              busy_q;
  logic [15:0]       inj_count_q;
  logic              overflow_q;
  logic              underflow_q;

  logic push;
  logic fifo_head;
  logic fifo_full;
  logic fifo_empty;
  logic eligible;
  logic inj_now;

  assign push     = bus.req && bus.gnt;
  assign eligible = bus.rvalid && !fifo_empty && fifo_head;

  uvmt_cv32e40s_rchk_fault_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.integrity),
    .pop       (bus.rvalid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An arm in the same cycle suppresses injection so the new sequence starts clean.
  always_comb begin
    inj_now = 1'b0;
    if (eligible && !cfg_arm_i && (state_q == ST_COUNT)) begin
      if (mode_q == MODE_RANDOM) begin
        inj_now = (lfsr_q[3:0] < interval_q[3:0]);
      end else begin
        inj_now = (cnt_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_OFF;
      interval_q  <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      busy_q      <= 1'b0;
      inj_count_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && fifo_full && !bus.rvalid) begin
        overflow_q <= 1'b1;
      end
      if (bus.rvalid && fifo_empty) begin
        underflow_q <= 1'b1;
      end
      if (inj_now && (inj_count_q != 16'hFFFF)) begin
        inj_count_q <= inj_count_q + 1'b1;
      end

      if (cfg_arm_i) begin
        mode_q     <= rchk_fault_mode_e'(cfg_mode_i);
        interval_q <= cfg_interval_i;
        mask_q     <= cfg_mask_i;
        cnt_q      <= cfg_interval_i;
        lfsr_q     <= LFSR_SEED;
        if (rchk_fault_mode_e'(cfg_mode_i) == MODE_OFF) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end else begin
          state_q <= ST_COUNT;
          busy_q  <= 1'b1;
        end
      end else if ((state_q == ST_COUNT) && eligible) begin
        // The LFSR only steps on eligible responses so the random pattern repeats per arm.
        if (mode_q == MODE_RANDOM) begin
          lfsr_q <= lfsr_next(lfsr_q);
        end else if (cnt_q == '0) begin
          if (mode_q == MODE_ONESHOT) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= interval_q;
          end
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign bus.rchk_fault  = bus.rchk ^ (inj_now ? mask_q : 5'b0);
  assign inj_now_o       = inj_now;
  assign inj_count_o     = inj_count_q;
  assign busy_o          = busy_q;
  assign overflow_err_o  = overflow_q;
  assign underflow_err_o = underflow_q;

endmodule

// File: tb/tb_uvmt_cv32e40s_rchk_fault_ctrl.sv
// Directed bench for the rchk fault controller: a vector table for the main sequences
// plus hand-written sequences for error flags, random mode and mid-sequence reset.
module tb_uvmt_cv32e40s_rchk_fault_ctrl;

  localparam logic [1:0] M_OFF      = 2'd0;
  localparam logic [1:0] M_ONESHOT  = 2'd1;
  localparam logic [1:0] M_PERIODIC = 2'd2;
  localparam logic [1:0] M_RANDOM   = 2'd3;

  typedef struct {
    logic        arm;
    logic [1:0]  mode;
    logic [15:0] interval;
    logic [4:0]  mask;
    logic        req;
    logic        gnt;
    logic        integ;
    logic        rvalid;
    logic [4:0]  rchk;
    logic [4:0]  exp_rchk;
    logic        exp_inj;
    logic        exp_busy;
    logic [15:0] exp_icnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_arm = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_interval = '0;
  logic [4:0]  cfg_mask = '0;
  logic        inj_now;
  logic [15:0] inj_count;
  logic        busy;
  logic        overflow_err;
  logic        underflow_err;

  int tests = 0;
  int fails = 0;

  uvmt_cv32e40s_rchk_fault_ctrl_if bus ();

  uvmt_cv32e40s_rchk_fault_ctrl #(
    .MAX_OUTSTANDING (2),
    .LFSR_SEED       (16'hACE1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_arm_i       (cfg_arm),
    .cfg_mode_i      (cfg_mode),
    .cfg_interval_i  (cfg_interval),
    .cfg_mask_i      (cfg_mask),
    .bus             (bus),
    .inj_now_o       (inj_now),
    .inj_count_o     (inj_count),
    .busy_o          (busy),
    .overflow_err_o  (overflow_err),
    .underflow_err_o (underflow_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk_idle();
    vec_t v;
    v = '{arm: 1'b0, mode: 2'd0, interval: 16'd0, mask: 5'd0, req: 1'b0, gnt: 1'b0,
          integ: 1'b0, rvalid: 1'b0, rchk: 5'd0, exp_rchk: 5'd0, exp_inj: 1'b0,
          exp_busy: 1'b0, exp_icnt: 16'd0};
    return v;
  endfunction

  function automatic vec_t mk_arm(logic [1:0] m, logic [15:0] iv, logic [4:0] mk,
                                  logic b, logic [15:0] ic);
    vec_t v = mk_idle();
    v.arm = 1'b1; v.mode = m; v.interval = iv; v.mask = mk;
    v.exp_busy = b; v.exp_icnt = ic;
    return v;
  endfunction

  function automatic vec_t mk_bus(logic push, logic integ, logic rv, logic [4:0] rc,
                                  logic [4:0] erc, logic inj, logic b, logic [15:0] ic);
    vec_t v = mk_idle();
    v.req = push; v.gnt = push; v.integ = integ; v.rvalid = rv; v.rchk = rc;
    v.exp_rchk = erc; v.exp_inj = inj; v.exp_busy = b; v.exp_icnt = ic;
    return v;
  endfunction

  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    cfg_arm       = v.arm;
    cfg_mode      = v.mode;
    cfg_interval  = v.interval;
    cfg_mask      = v.mask;
    bus.req       = v.req;
    bus.gnt       = v.gnt;
    bus.integrity = v.integ;
    bus.rvalid    = v.rvalid;
    bus.rchk      = v.rchk;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mk_idle());
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // One non-pipelined read: address phase, then its response.
  task automatic run_read(input logic integ, input logic [4:0] rc, input logic [4:0] erc,
                          input logic inj, input string tag);
    applyStimulus(mk_bus(1'b1, integ, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 16'd0));
    applyStimulus(mk_bus(1'b0, 1'b0, 1'b1, rc, erc, inj, 1'b0, 16'd0));
    checkOutput({tag, " rchk"}, 32'(bus.rchk_fault), 32'(erc));
    checkOutput({tag, " inj"}, 32'(inj_now), 32'(inj));
  endtask

  vec_t tbl[25];

  initial begin
    logic [15:0] lfsr;
    int          n_inj;
    logic        e_inj;

    // ONESHOT interval 2: third eligible response gets bit0 flipped
    tbl[0]  = mk_arm(M_ONESHOT, 16'd2, 5'h01, 1'b0, 16'd0);
    tbl[1]  = mk_bus(1, 1, 0, 5'h00, 5'h00, 0, 1, 16'd0);
    tbl[2]  = mk_bus(0, 0, 1, 5'h0A, 5'h0A, 0, 1, 16'd0);
    tbl[3]  = mk_bus(1, 1, 0, 5'h00, 5'h00, 0, 1, 16'd0);
    tbl[4]  = mk_bus(0, 0, 1, 5'h0A, 5'h0A, 0, 1, 16'd0);
    tbl[5]  = mk_bus(1, 1, 0, 5'h00, 5'h00, 0, 1, 16'd0);
    tbl[6]  = mk_bus(0, 0, 1, 5'h0A, 5'h0B, 1, 1, 16'd0);
    tbl[7]  = mk_bus(1, 1, 0, 5'h00, 5'h00, 0, 0, 16'd1);
    tbl[8]  = mk_bus(0, 0, 1, 5'h0A, 5'h0A, 0, 0, 16'd1);
    tbl[9]  = mk_bus(1, 1, 0, 5'h00, 5'h00, 0, 0, 16'd1);
    tbl[10] = mk_bus(0, 0, 1, 5'h0A, 5'h0A, 0, 0, 16'd1);
    // PERIODIC interval 0, integrity 1,0,1
    tbl[11] = mk_arm(M_PERIODIC, 16'd0, 5'h1F, 1'b0, 16'd1);
    tbl[12] = mk_bus(1, 1, 0, 5'h00, 5'h00, 0, 1, 16'd1);
    tbl[13] = mk_bus(0, 0, 1, 5'h05, 5'h1A, 1, 1, 16'd1);
    tbl[14] = mk_bus(1, 0, 0, 5'h00, 5'h00, 0, 1, 16'd2);
    tbl[15] = mk_bus(0, 0, 1, 5'h05, 5'h05, 0, 1, 16'd2);
    tbl[16] = mk_bus(1, 1, 0, 5'h00, 5'h00, 0, 1, 16'd2);
    tbl[17] = mk_bus(0, 0, 1, 5'h05, 5'h1A, 1, 1, 16'd2);
    // ONESHOT interval 1, pipelined A(1) B(1) C(0) D(1) with push+pop while full
    tbl[18] = mk_arm(M_ONESHOT, 16'd1, 5'h04, 1'b1, 16'd3);
    tbl[19] = mk_bus(1, 1, 0, 5'h10, 5'h10, 0, 1, 16'd3);
    tbl[20] = mk_bus(1, 1, 0, 5'h10, 5'h10, 0, 1, 16'd3);
    tbl[21] = mk_bus(1, 0, 1, 5'h10, 5'h10, 0, 1, 16'd3);
    tbl[22] = mk_bus(1, 1, 1, 5'h10, 5'h14, 1, 1, 16'd3);
    tbl[23] = mk_bus(0, 0, 1, 5'h10, 5'h10, 0, 0, 16'd4);
    tbl[24] = mk_bus(0, 0, 1, 5'h10, 5'h10, 0, 0, 16'd4);

    bus.req = 1'b0; bus.gnt = 1'b0; bus.integrity = 1'b0; bus.rvalid = 1'b0; bus.rchk = '0;
    do_reset();

    bus.rchk = 5'h15;
    #1;
    checkOutput("reset rchk passthrough", 32'(bus.rchk_fault), 32'h15);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset inj_count", 32'(inj_count), 32'h0);
    checkOutput("reset overflow", 32'(overflow_err), 32'h0);
    checkOutput("reset underflow", 32'(underflow_err), 32'h0);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("row%0d rchk", i), 32'(bus.rchk_fault), 32'(tbl[i].exp_rchk));
      checkOutput($sformatf("row%0d inj", i), 32'(inj_now), 32'(tbl[i].exp_inj));
      checkOutput($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      checkOutput($sformatf("row%0d inj_count", i), 32'(inj_count), 32'(tbl[i].exp_icnt));
    end
    applyStimulus(mk_idle());
    checkOutput("pipelined overflow", 32'(overflow_err), 32'h0);
    checkOutput("pipelined underflow", 32'(underflow_err), 32'h0);

    // Underflow while armed with cnt 0, then overflow with three unanswered pushes
    applyStimulus(mk_arm(M_PERIODIC, 16'd0, 5'h1F, 1'b0, 16'd4));
    applyStimulus(mk_bus(0, 0, 1, 5'h13, 5'h13, 0, 1, 16'd4));
    checkOutput("underflow rchk", 32'(bus.rchk_fault), 32'h13);
    checkOutput("underflow inj", 32'(inj_now), 32'h0);
    applyStimulus(mk_idle());
    checkOutput("underflow flag", 32'(underflow_err), 32'h1);
    checkOutput("no overflow yet", 32'(overflow_err), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(mk_bus(1, 1, 0, 5'h00, 5'h00, 0, 1, 16'd4));
    applyStimulus(mk_idle());
    checkOutput("overflow flag", 32'(overflow_err), 32'h1);
    checkOutput("inj_count held", 32'(inj_count), 32'h4);

    // RANDOM threshold F, replayed after re-arm from the same seed
    do_reset();
    n_inj = 0;
    for (int run = 0; run < 2; run++) begin
      applyStimulus(mk_arm(M_RANDOM, 16'h000F, 5'h1F, 1'b0, 16'd0));
      lfsr = 16'hACE1;
      for (int k = 0; k < 20; k++) begin
        if (k == 7) begin
          run_read(1'b0, 5'h00, 5'h00, 1'b0, $sformatf("rnd%0d.%0d", run, k));
        end else begin
          e_inj = (lfsr[3:0] != 4'hF);
          if (e_inj) n_inj++;
          run_read(1'b1, 5'h00, e_inj ? 5'h1F : 5'h00, e_inj, $sformatf("rnd%0d.%0d", run, k));
          lfsr = lfsr_step(lfsr);
        end
      end
      applyStimulus(mk_idle());
      checkOutput($sformatf("rnd%0d inj_count", run), 32'(inj_count), 32'(n_inj));
      checkOutput($sformatf("rnd%0d busy", run), 32'(busy), 32'h1);
    end

    // ONESHOT interval 5 interrupted by reset after two responses
    do_reset();
    applyStimulus(mk_arm(M_ONESHOT, 16'd5, 5'h1F, 1'b0, 16'd0));
    run_read(1'b1, 5'h0C, 5'h0C, 1'b0, "pre-rst 0");
    run_read(1'b1, 5'h0C, 5'h0C, 1'b0, "pre-rst 1");
    checkOutput("pre-rst busy", 32'(busy), 32'h1);
    do_reset();
    checkOutput("post-rst busy", 32'(busy), 32'h0);
    checkOutput("post-rst inj_count", 32'(inj_count), 32'h0);
    for (int k = 0; k < 6; k++) run_read(1'b1, 5'h0C, 5'h0C, 1'b0, $sformatf("post-rst %0d", k));
    applyStimulus(mk_idle());
    checkOutput("post-rst final inj_count", 32'(inj_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
